// File: rtl/cp0_regfile_if.sv
// Coprocessor-0 register file bus: MTC0/MFC0 access, exception commit and
// the feedback signals returned to the exception unit.
interface cp0_regfile_if;
  // MTC0 / MFC0
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [2:0]  mtc0_sel;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [2:0]  mfc0_sel;
  logic [31:0] mfc0_rdata;
  // Exception commit
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        badvaddr_we;
  logic [31:0] badvaddr_in;
  logic        clear_exl;
  logic [5:0]  hw_int;
  // Feedback
  logic [31:0] epc_out;
  logic [31:0] ebase;
  logic        sr_exl;
  logic        sr_bev;
  logic        cause_iv;
  logic        allow_int;
  logic [7:0]  interrupt_flag;
  logic        timer_int;

  // Pipeline / exception-unit side
  modport master (
    output mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata, mfc0_addr, mfc0_sel,
    output exc_we, exc_code, exc_epc, exc_bd, badvaddr_we, badvaddr_in, clear_exl, hw_int,
    input  mfc0_rdata, epc_out, ebase, sr_exl, sr_bev, cause_iv, allow_int,
    input  interrupt_flag, timer_int
  );

  // Register file side
  modport slave (
    input  mtc0_we, mtc0_addr, mtc0_sel, mtc0_wdata, mfc0_addr, mfc0_sel,
    input  exc_we, exc_code, exc_epc, exc_bd, badvaddr_we, badvaddr_in, clear_exl, hw_int,
    output mfc0_rdata, epc_out, ebase, sr_exl, sr_bev, cause_iv, allow_int,
    output interrupt_flag, timer_int
  );
endinterface

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr/EBase, the
// Count/Compare timer and interrupt-pending collection.
module cp0_regfile #(
  parameter logic [31:0] EBASE_RST = 32'h8000_0000,
  parameter int unsigned TIMER_IP  = 7
) (
  input logic           clk,
  input logic           resetn,
  cp0_regfile_if.slave  bus
);

  localparam logic [31:0] StatusRst   = 32'h0040_0000;
  localparam logic [31:0] StatusWmask = 32'h0040_FF03;
  localparam logic [31:0] CauseWmask  = 32'h0080_0300;
  localparam logic [31:0] EbaseWmask  = 32'h3FFF_F000;

  localparam int unsigned ExlBit = 1;
  localparam int unsigned TiBit  = 30;
  localparam int unsigned BdBit  = 31;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] ebase_q, ebase_d;
  logic        phase_q, phase_d;
  logic        ti_d;
  logic [31:0] ebase_rd;

  logic wr_badvaddr, wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;

  // EBase top bits are hardwired to kseg0/kseg1 region, low 12 bits to zero.
  assign ebase_rd = {2'b10, ebase_q[29:12], 12'h000};

  // MTC0 address decode
  always_comb begin
    wr_badvaddr = 1'b0;
    wr_count    = 1'b0;
    wr_compare  = 1'b0;
    wr_status   = 1'b0;
    wr_cause    = 1'b0;
    wr_epc      = 1'b0;
    wr_ebase    = 1'b0;
    if (bus.mtc0_we) begin
      case ({bus.mtc0_addr, bus.mtc0_sel})
        {5'd8,  3'd0}: wr_badvaddr = 1'b1;
        {5'd9,  3'd0}: wr_count    = 1'b1;
        {5'd11, 3'd0}: wr_compare  = 1'b1;
        {5'd12, 3'd0}: wr_status   = 1'b1;
        {5'd13, 3'd0}: wr_cause    = 1'b1;
        {5'd14, 3'd0}: wr_epc      = 1'b1;
        {5'd15, 3'd1}: wr_ebase    = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state: MTC0 first, then exception commit overrides its fields
  always_comb begin
    status_d   = status_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    ebase_d    = ebase_q;
    phase_d    = ~phase_q;
    count_d    = phase_q ? count_q + 32'd1 : count_q;

    // TI is sticky until Compare is rewritten; the clear beats a match.
    ti_d = cause_q[TiBit] | (count_q == compare_q);

    if (wr_count) begin
      count_d = bus.mtc0_wdata;
      phase_d = 1'b0;
    end
    if (wr_compare) begin
      compare_d = bus.mtc0_wdata;
      ti_d      = 1'b0;
    end
    if (wr_status)   status_d   = (status_q & ~StatusWmask) | (bus.mtc0_wdata & StatusWmask);
    if (wr_cause)    cause_d    = (cause_q & ~CauseWmask) | (bus.mtc0_wdata & CauseWmask);
    if (wr_ebase)    ebase_d    = (ebase_q & ~EbaseWmask) | (bus.mtc0_wdata & EbaseWmask);
    if (wr_epc)      epc_d      = bus.mtc0_wdata;
    if (wr_badvaddr) badvaddr_d = bus.mtc0_wdata;

    if (bus.clear_exl) status_d[ExlBit] = 1'b0;

    if (bus.exc_we) begin
      status_d[ExlBit] = 1'b1;
      cause_d[6:2]     = bus.exc_code;
      // A nested exception keeps the original return point.
      if (!status_q[ExlBit]) begin
        epc_d          = bus.exc_epc;
        cause_d[BdBit] = bus.exc_bd;
      end else begin
        epc_d = epc_q;
      end
    end

    if (bus.badvaddr_we) badvaddr_d = bus.badvaddr_in;

    // Hardware interrupt lines resampled every cycle; timer shares one IP bit.
    cause_d[15:10]        = bus.hw_int;
    cause_d[8 + TIMER_IP] = cause_d[8 + TIMER_IP] | ti_d;
    cause_d[TiBit]        = ti_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      status_q   <= StatusRst;
      cause_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      ebase_q    <= EBASE_RST;
      phase_q    <= 1'b0;
    end else begin
      status_q   <= status_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      ebase_q    <= ebase_d;
      phase_q    <= phase_d;
    end
  end

  // MFC0 read mux, pre-edge values only
  always_comb begin
    bus.mfc0_rdata = '0;
    case ({bus.mfc0_addr, bus.mfc0_sel})
      {5'd8,  3'd0}: bus.mfc0_rdata = badvaddr_q;
      {5'd9,  3'd0}: bus.mfc0_rdata = count_q;
      {5'd11, 3'd0}: bus.mfc0_rdata = compare_q;
      {5'd12, 3'd0}: bus.mfc0_rdata = status_q;
      {5'd13, 3'd0}: bus.mfc0_rdata = cause_q;
      {5'd14, 3'd0}: bus.mfc0_rdata = epc_q;
      {5'd15, 3'd1}: bus.mfc0_rdata = ebase_rd;
      default: ;
    endcase
  end

  assign bus.epc_out        = epc_q;
  assign bus.ebase          = ebase_rd;
  assign bus.sr_exl         = status_q[ExlBit];
  assign bus.sr_bev         = status_q[22];
  assign bus.cause_iv       = cause_q[23];
  assign bus.allow_int      = status_q[0] & ~status_q[ExlBit];
  assign bus.interrupt_flag = cause_q[15:8] & status_q[15:8];
  assign bus.timer_int      = cause_q[TiBit];

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed bench for cp0_regfile: MTC0/MFC0 vector table plus hand sequences
// for the timer, exception commit and Count corner cases.
module tb_cp0_regfile;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  cp0_regfile_if bus ();

  cp0_regfile #(
    .EBASE_RST (32'h8000_0000),
    .TIMER_IP  (7)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [2:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [2:0] s, output logic [31:0] d);
    bus.mfc0_addr = a;
    bus.mfc0_sel  = s;
    #1;
    d = bus.mfc0_rdata;
  endtask

  task automatic wr(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = a;
    bus.mtc0_sel   = s;
    bus.mtc0_wdata = d;
    tick();
    bus.mtc0_we    = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    n_vec = 0;
    n_err = 0;
    bus.mtc0_we = 0; bus.mtc0_addr = 0; bus.mtc0_sel = 0; bus.mtc0_wdata = 0;
    bus.mfc0_addr = 0; bus.mfc0_sel = 0;
    bus.exc_we = 0; bus.exc_code = 0; bus.exc_epc = 0; bus.exc_bd = 0;
    bus.badvaddr_we = 0; bus.badvaddr_in = 0; bus.clear_exl = 0; bus.hw_int = 0;

    // Compare first so the reset-time Count==Compare match is cleared.
    vecs[0]  = '{5'd11, 3'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1]  = '{5'd12, 3'd0, 32'hFFFF_FFFF, 32'h0040_FF03};
    vecs[2]  = '{5'd12, 3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{5'd13, 3'd0, 32'hFFFF_FFFF, 32'h0080_0300};
    vecs[4]  = '{5'd13, 3'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{5'd15, 3'd1, 32'hFFFF_FFFF, 32'hBFFF_F000};
    vecs[6]  = '{5'd15, 3'd1, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{5'd14, 3'd0, 32'h1234_5678, 32'h1234_5678};
    vecs[8]  = '{5'd7,  3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{5'd15, 3'd0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{5'd12, 3'd1, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset
    resetn = 1'b0;
    tick();
    tick();
    rd(5'd12, 3'd0, r);
    check("reset_status", r, 32'h0040_0000);
    check("reset_bev", {31'd0, bus.sr_bev}, 32'd1);
    check("reset_ebase", bus.ebase, 32'h8000_0000);
    check("reset_allow_int", {31'd0, bus.allow_int}, 32'd0);
    rd(5'd13, 3'd0, r);
    check("reset_cause", r, 32'h0000_0000);
    resetn = 1'b1;

    // Table: write then read back
    for (int i = 0; i < 11; i++) begin
      wr(vecs[i].addr, vecs[i].sel, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].sel, r);
      check($sformatf("vec%0d", i), r, vecs[i].exp);
    end
    check("bev_after_clear", {31'd0, bus.sr_bev}, 32'd0);

    // MFC0 sees pre-edge value while a write to the same register is pending
    bus.mfc0_addr  = 5'd14;
    bus.mfc0_sel   = 3'd0;
    bus.mtc0_we    = 1'b1;
    bus.mtc0_addr  = 5'd14;
    bus.mtc0_sel   = 3'd0;
    bus.mtc0_wdata = 32'hCAFE_0000;
    #1;
    check("mfc0_no_forward", bus.mfc0_rdata, 32'h1234_5678);
    tick();
    bus.mtc0_we = 1'b0;
    check("mfc0_after_write", bus.mfc0_rdata, 32'hCAFE_0000);

    // Timer: Count=0, Compare=5, IM7 and IE set
    wr(5'd12, 3'd0, 32'h0000_8001);
    wr(5'd9, 3'd0, 32'h0000_0000);
    wr(5'd11, 3'd0, 32'h0000_0005);
    for (int i = 0; i < 9; i++) tick();
    rd(5'd9, 3'd0, r);
    check("count_at_10", r, 32'd5);
    check("ti_before", {31'd0, bus.timer_int}, 32'd0);
    tick();
    check("ti_set", {31'd0, bus.timer_int}, 32'd1);
    rd(5'd13, 3'd0, r);
    check("cause_ti", {31'd0, r[30]}, 32'd1);
    tick();
    check("int_flag_ip7", {24'd0, bus.interrupt_flag}, 32'h0000_0080);
    wr(5'd11, 3'd0, 32'h0000_1000);
    check("ti_cleared", {31'd0, bus.timer_int}, 32'd0);
    tick();
    check("int_flag_clear", {24'd0, bus.interrupt_flag}, 32'h0000_0000);

    // First exception: EXL 0 -> 1, EPC and BD captured
    bus.exc_we   = 1'b1;
    bus.exc_code = 5'h0C;
    bus.exc_epc  = 32'hBFC0_0100;
    bus.exc_bd   = 1'b1;
    tick();
    check("exc1_epc", bus.epc_out, 32'hBFC0_0100);
    check("exc1_exl", {31'd0, bus.sr_exl}, 32'd1);
    check("exc1_allow", {31'd0, bus.allow_int}, 32'd0);
    rd(5'd13, 3'd0, r);
    check("exc1_cause", r & 32'h8000_007C, 32'h8000_0030);
    // Nested: EPC/BD held, ExcCode updated
    bus.exc_code = 5'h04;
    bus.exc_epc  = 32'h0000_1234;
    bus.exc_bd   = 1'b0;
    tick();
    check("exc2_epc", bus.epc_out, 32'hBFC0_0100);
    rd(5'd13, 3'd0, r);
    check("exc2_cause", r & 32'h8000_007C, 32'h8000_0010);
    // exc_we beats clear_exl
    bus.clear_exl = 1'b1;
    tick();
    check("exc_vs_clear", {31'd0, bus.sr_exl}, 32'd1);
    bus.exc_we = 1'b0;
    tick();
    bus.clear_exl = 1'b0;
    check("clear_exl", {31'd0, bus.sr_exl}, 32'd0);
    check("allow_after_eret", {31'd0, bus.allow_int}, 32'd1);

    // Same-cycle MTC0 Status and exception commit; plus BadVAddr capture
    bus.mtc0_we     = 1'b1;
    bus.mtc0_addr   = 5'd12;
    bus.mtc0_sel    = 3'd0;
    bus.mtc0_wdata  = 32'h0000_0100;
    bus.exc_we      = 1'b1;
    bus.exc_epc     = 32'h0000_2000;
    bus.badvaddr_we = 1'b1;
    bus.badvaddr_in = 32'hAAAA_5555;
    tick();
    bus.mtc0_we     = 1'b0;
    bus.exc_we      = 1'b0;
    bus.badvaddr_we = 1'b0;
    rd(5'd12, 3'd0, r);
    check("mtc0_exc_status", r, 32'h0000_0102);
    check("mtc0_exc_epc", bus.epc_out, 32'h0000_2000);
    rd(5'd8, 3'd0, r);
    check("badvaddr", r, 32'hAAAA_5555);

    // hw_int sampled into IP[7:2]
    bus.hw_int = 6'b10_0101;
    tick();
    rd(5'd13, 3'd0, r);
    check("hw_int_ip", {26'd0, r[15:10]}, 32'h0000_0025);
    bus.hw_int = 6'd0;

    // Count wrap
    wr(5'd9, 3'd0, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, 3'd0, r);
    check("wrap_hold", r, 32'hFFFF_FFFF);
    tick();
    rd(5'd9, 3'd0, r);
    check("wrap_zero", r, 32'h0000_0000);
    // Phase now 0; one tick puts us on an increment cycle, then load Count
    tick();
    wr(5'd9, 3'd0, 32'h0000_0100);
    rd(5'd9, 3'd0, r);
    check("load_wins", r, 32'h0000_0100);
    tick();
    rd(5'd9, 3'd0, r);
    check("load_hold", r, 32'h0000_0100);
    tick();
    rd(5'd9, 3'd0, r);
    check("load_inc", r, 32'h0000_0101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
